// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the PC fetch sequencer (pc_fetch_ctrl).
package pc_ctrl_pkg;

  localparam int          XLEN_DEF         = 64;
  localparam logic [63:0] DEF_RESET_VECTOR = 64'h0;
  localparam int          INSTR_BYTES      = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD
  } fetch_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC datapath: sequential PC+4, branch target br_pc+(br_imm<<1), and select.
module next_pc_sel
  import pc_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_br_pc,
  input  logic [XLEN-1:0] i_br_imm,
  input  logic            i_sel,
  output logic [XLEN-1:0] o_seq_pc,
  output logic [XLEN-1:0] o_target,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_misalign
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);

  logic [XLEN-1:0] w_raw_target;

  // Both adders wrap at XLEN bits; the carry out is intentionally dropped.
  assign o_seq_pc     = i_pc + XLEN'(INSTR_BYTES);
  assign w_raw_target = i_br_pc + (i_br_imm << 1);
  assign o_target     = w_raw_target & ALIGN_MASK;
  assign o_misalign   = w_raw_target[1];
  assign o_next_pc    = i_sel ? o_target : o_seq_pc;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register, instruction-memory request sequencer and fetch->decode handoff.
// Define FETCH_MISALIGN_TRAP_EN to trap on halfword-aligned branch targets.
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR[XLEN-1:0]
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_stall,
  input  logic            i_br_taken,
  input  logic [XLEN-1:0] i_br_pc,
  input  logic [XLEN-1:0] i_br_imm,
  output logic            o_imem_req_valid,
  output logic [XLEN-1:0] o_imem_req_addr,
  input  logic            i_imem_req_ready,
  input  logic            i_imem_rsp_valid,
  input  logic [31:0]     i_imem_rsp_data,
  output logic            o_if_valid,
  input  logic            i_if_ready,
  output logic [XLEN-1:0] o_if_pc,
  output logic [31:0]     o_if_instr,
  output logic            o_misalign_trap
);

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_drop;
  logic            r_req_valid;
  logic [XLEN-1:0] r_req_addr;
  logic            r_if_valid;
  logic [XLEN-1:0] r_if_pc;
  logic [31:0]     r_if_instr;
  logic            r_trap;

  logic [XLEN-1:0] w_seq_pc;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_next_pc;
  logic            w_misalign;
  logic            w_trap;
  logic [XLEN-1:0] w_pc_upd;

  next_pc_sel #(
    .XLEN (XLEN)
  ) u_next_pc_sel (
    .i_pc       (r_pc),
    .i_br_pc    (i_br_pc),
    .i_br_imm   (i_br_imm),
    .i_sel      (i_br_taken),
    .o_seq_pc   (w_seq_pc),
    .o_target   (w_target),
    .o_next_pc  (w_next_pc),
    .o_misalign (w_misalign)
  );

  // A trapping redirect leaves the PC where it was but still kills the fetch.
  assign w_trap   = TRAP_EN & i_br_taken & w_misalign;
  assign w_pc_upd = w_trap ? r_pc : w_next_pc;

  // NOTE: all state here uses <= so every branch of the FSM sees the
  // pre-edge values of r_pc/r_drop regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pc        <= RESET_VECTOR;
      r_drop      <= 1'b0;
      r_req_valid <= 1'b0;
      r_req_addr  <= RESET_VECTOR;
      r_if_valid  <= 1'b0;
      r_if_pc     <= '0;
      r_if_instr  <= '0;
      r_trap      <= 1'b0;
    end else begin
      r_trap <= w_trap;
      case (r_state)
        ST_IDLE: begin
          if (i_br_taken) begin
            r_pc <= w_pc_upd;
          end else if (!i_stall) begin
            r_req_valid <= 1'b1;
            r_req_addr  <= r_pc;
            r_state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          // The request address stays put until accepted; its response is dropped.
          if (i_br_taken) begin
            r_pc   <= w_pc_upd;
            r_drop <= 1'b1;
          end
          if (i_imem_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_br_taken) begin
            r_pc   <= w_pc_upd;
            r_drop <= !i_imem_rsp_valid;
            if (i_imem_rsp_valid) r_state <= ST_IDLE;
          end else if (i_imem_rsp_valid) begin
            if (r_drop) begin
              r_drop  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_if_valid <= 1'b1;
              r_if_pc    <= r_pc;
              r_if_instr <= i_imem_rsp_data;
              r_state    <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (i_br_taken || i_if_ready) begin
            r_pc       <= w_pc_upd;
            r_if_valid <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_imem_req_valid = r_req_valid;
  assign o_imem_req_addr  = r_req_addr;
  assign o_if_valid       = r_if_valid;
  assign o_if_pc          = r_if_pc;
  assign o_if_instr       = r_if_instr;
  assign o_misalign_trap  = r_trap;

  a_req_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (r_req_valid && !i_imem_req_ready) |=> (r_req_valid && $stable(r_req_addr)));

  a_if_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (r_if_valid && !i_if_ready && !i_br_taken)
      |=> (r_if_valid && $stable(r_if_pc) && $stable(r_if_instr)));

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: cycle table plus multi-cycle corner sequences.
module tb_pc_fetch_ctrl;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br_taken;
  logic [63:0] br_pc;
  logic [63:0] br_imm;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        misalign_trap;

  int n_pass  = 0;
  int n_total = 0;

  pc_fetch_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_stall          (stall),
    .i_br_taken       (br_taken),
    .i_br_pc          (br_pc),
    .i_br_imm         (br_imm),
    .o_imem_req_valid (imem_req_valid),
    .o_imem_req_addr  (imem_req_addr),
    .i_imem_req_ready (imem_req_ready),
    .i_imem_rsp_valid (imem_rsp_valid),
    .i_imem_rsp_data  (imem_rsp_data),
    .o_if_valid       (if_valid),
    .i_if_ready       (if_ready),
    .o_if_pc          (if_pc),
    .o_if_instr       (if_instr),
    .o_misalign_trap  (misalign_trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: an addi whose immediate is the low address bits.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {a[11:0], 20'h00013};
  endfunction

  // Memory model: responds rsp_lat cycles after the accepting edge.
  int          rsp_lat = 1;
  int          pend_cnt = 0;
  logic [63:0] pend_addr = '0;
  always @(posedge clk) begin
    #3;
    imem_rsp_valid = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      pend_cnt  = rsp_lat;
      pend_addr = imem_req_addr;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic expect_out(input string tag, input logic rv, input logic [63:0] addr,
                            input logic ifv, input logic [63:0] pc, input logic trap);
    check({tag, " req_valid"}, 64'(imem_req_valid), 64'(rv));
    check({tag, " req_addr"},  imem_req_addr,       addr);
    check({tag, " if_valid"},  64'(if_valid),       64'(ifv));
    check({tag, " if_pc"},     if_pc,               pc);
    check({tag, " trap"},      64'(misalign_trap),  64'(trap));
    if (ifv) check({tag, " if_instr"}, 64'(if_instr), 64'(mem_word(pc)));
  endtask

  task automatic step(input logic rdy, input logic st, input logic br,
                      input logic [63:0] bpc, input logic [63:0] bimm, input logic ifr);
    @(posedge clk);
    #1;
    imem_req_ready = rdy;
    stall          = st;
    br_taken       = br;
    br_pc          = bpc;
    br_imm         = bimm;
    if_ready       = ifr;
    @(negedge clk);
  endtask

  typedef struct {
    logic        stall;
    logic        br;
    logic [63:0] bpc;
    logic [63:0] bimm;
    logic        ifr;
    logic        rv;
    logic [63:0] addr;
    logic        ifv;
    logic [63:0] pc;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic br, input logic [63:0] bpc,
                              input logic [63:0] bimm, input logic ifr, input logic rv,
                              input logic [63:0] addr, input logic ifv, input logic [63:0] pc);
    vec_t v;
    v.stall = st;  v.br = br;     v.bpc = bpc; v.bimm = bimm; v.ifr = ifr;
    v.rv    = rv;  v.addr = addr; v.ifv = ifv; v.pc = pc;
    return v;
  endfunction

  localparam int NVEC = 29;
  vec_t vecs [NVEC];

  initial begin
    // Each row: inputs driven during the cycle, outputs expected during that cycle.
    vecs[0]  = mk(0, 0, 64'h0, 64'h0, 1, 0, 64'h000, 0, 64'h000);
    vecs[1]  = mk(0, 0, 64'h0, 64'h0, 1, 1, 64'h000, 0, 64'h000);
    vecs[2]  = mk(0, 0, 64'h0, 64'h0, 1, 0, 64'h000, 0, 64'h000);
    vecs[3]  = mk(0, 0, 64'h0, 64'h0, 1, 0, 64'h000, 1, 64'h000);
    vecs[4]  = mk(0, 0, 64'h0, 64'h0, 1, 0, 64'h000, 0, 64'h000);
    vecs[5]  = mk(0, 0, 64'h0, 64'h0, 1, 1, 64'h004, 0, 64'h000);
    vecs[6]  = mk(0, 0, 64'h0, 64'h0, 1, 0, 64'h004, 0, 64'h000);
    vecs[7]  = mk(0, 0, 64'h0, 64'h0, 1, 0, 64'h004, 1, 64'h004);
    vecs[8]  = mk(0, 0, 64'h0, 64'h0, 1, 0, 64'h004, 0, 64'h004);
    vecs[9]  = mk(0, 0, 64'h0, 64'h0, 1, 1, 64'h008, 0, 64'h004);
    vecs[10] = mk(0, 0, 64'h0, 64'h0, 1, 0, 64'h008, 0, 64'h004);
    vecs[11] = mk(0, 1, 64'h100, 64'h20, 1, 0, 64'h008, 1, 64'h008);
    vecs[12] = mk(0, 0, 64'h0, 64'h0, 1, 0, 64'h008, 0, 64'h008);
    vecs[13] = mk(0, 0, 64'h0, 64'h0, 1, 1, 64'h140, 0, 64'h008);
    vecs[14] = mk(0, 1, 64'h200, 64'h0, 1, 0, 64'h140, 0, 64'h008);
    vecs[15] = mk(0, 0, 64'h0, 64'h0, 1, 0, 64'h140, 0, 64'h008);
    vecs[16] = mk(0, 0, 64'h0, 64'h0, 1, 1, 64'h200, 0, 64'h008);
    vecs[17] = mk(0, 0, 64'h0, 64'h0, 1, 0, 64'h200, 0, 64'h008);
    vecs[18] = mk(1, 0, 64'h0, 64'h0, 0, 0, 64'h200, 1, 64'h200);
    vecs[19] = mk(1, 0, 64'h0, 64'h0, 1, 0, 64'h200, 1, 64'h200);
    vecs[20] = mk(1, 0, 64'h0, 64'h0, 1, 0, 64'h200, 0, 64'h200);
    vecs[21] = mk(0, 0, 64'h0, 64'h0, 1, 0, 64'h200, 0, 64'h200);
    vecs[22] = mk(0, 1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 1, 1, 64'h204, 0, 64'h200);
    vecs[23] = mk(0, 0, 64'h0, 64'h0, 1, 0, 64'h204, 0, 64'h200);
    vecs[24] = mk(0, 0, 64'h0, 64'h0, 1, 0, 64'h204, 0, 64'h200);
    vecs[25] = mk(0, 0, 64'h0, 64'h0, 1, 1, 64'h010, 0, 64'h200);
    vecs[26] = mk(0, 0, 64'h0, 64'h0, 1, 0, 64'h010, 0, 64'h200);
    vecs[27] = mk(0, 0, 64'h0, 64'h0, 1, 0, 64'h010, 1, 64'h010);
    vecs[28] = mk(0, 0, 64'h0, 64'h0, 1, 0, 64'h010, 0, 64'h010);

    rst_n          = 1'b0;
    stall          = 1'b0;
    br_taken       = 1'b0;
    br_pc          = '0;
    br_imm         = '0;
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;

    repeat (2) @(negedge clk);
    expect_out("reset", 0, 64'h0, 0, 64'h0, 0);
    check("reset if_instr", 64'(if_instr), 64'h0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      if (i != 0) begin
        @(posedge clk);
        #1;
      end
      stall    = vecs[i].stall;
      br_taken = vecs[i].br;
      br_pc    = vecs[i].bpc;
      br_imm   = vecs[i].bimm;
      if_ready = vecs[i].ifr;
      @(negedge clk);
      expect_out($sformatf("vec%0d", i), vecs[i].rv, vecs[i].addr, vecs[i].ifv, vecs[i].pc, 1'b0);
    end

    // Backpressured request with a redirect while the address is held (pc=0x14).
    step(0, 0, 0, 64'h0,   64'h0, 1); expect_out("bp0",   1, 64'h014, 0, 64'h010, 0);
    step(0, 0, 1, 64'h400, 64'h8, 1); expect_out("bp1",   1, 64'h014, 0, 64'h010, 0);
    step(0, 0, 0, 64'h0,   64'h0, 1); expect_out("bp2",   1, 64'h014, 0, 64'h010, 0);
    step(1, 0, 0, 64'h0,   64'h0, 1); expect_out("bp3",   1, 64'h014, 0, 64'h010, 0);
    step(1, 0, 0, 64'h0,   64'h0, 1); expect_out("bpw",   0, 64'h014, 0, 64'h010, 0);
    step(1, 0, 0, 64'h0,   64'h0, 1); expect_out("bpi",   0, 64'h014, 0, 64'h010, 0);
    step(1, 0, 0, 64'h0,   64'h0, 1); expect_out("bpreq", 1, 64'h410, 0, 64'h010, 0);
    step(1, 0, 0, 64'h0,   64'h0, 1); expect_out("bpw2",  0, 64'h410, 0, 64'h010, 0);
    step(1, 0, 0, 64'h0,   64'h0, 1); expect_out("bphld", 0, 64'h410, 1, 64'h410, 0);

    // Redirect in WAIT before a slow response; the late response must be dropped.
    rsp_lat = 3;
    step(1, 0, 0, 64'h0,   64'h0, 1); expect_out("sl_i",  0, 64'h410, 0, 64'h410, 0);
    step(1, 0, 0, 64'h0,   64'h0, 1); expect_out("sl_r",  1, 64'h414, 0, 64'h410, 0);
    step(1, 0, 1, 64'h500, 64'h0, 1); expect_out("sl_w0", 0, 64'h414, 0, 64'h410, 0);
    step(1, 0, 0, 64'h0,   64'h0, 1); expect_out("sl_w1", 0, 64'h414, 0, 64'h410, 0);
    rsp_lat = 1;
    step(1, 0, 0, 64'h0,   64'h0, 1); expect_out("sl_w2", 0, 64'h414, 0, 64'h410, 0);
    step(1, 0, 0, 64'h0,   64'h0, 1); expect_out("sl_i2", 0, 64'h414, 0, 64'h410, 0);
    step(1, 0, 0, 64'h0,   64'h0, 1); expect_out("sl_r2", 1, 64'h500, 0, 64'h410, 0);
    step(1, 0, 0, 64'h0,   64'h0, 1); expect_out("sl_w3", 0, 64'h500, 0, 64'h410, 0);

    // Halfword-aligned target from HOLD: trap keeps pc, otherwise align down.
    step(1, 0, 1, 64'h600, 64'h1, 1); expect_out("mis_h", 0, 64'h500, 1, 64'h500, 0);
    rsp_lat = 2;
    step(1, 0, 0, 64'h0,   64'h0, 1); expect_out("mis_i", 0, 64'h500, 0, 64'h500, TRAP_EN);
    step(1, 0, 0, 64'h0,   64'h0, 1);
    expect_out("mis_r", 1, TRAP_EN ? 64'h500 : 64'h600, 0, 64'h500, 0);

    // Reset while a response is outstanding; it arrives after release and is ignored.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    expect_out("rst_mid", 0, 64'h0, 0, 64'h0, 0);
    check("rst_mid if_instr", 64'(if_instr), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    expect_out("rst_rel", 0, 64'h0, 0, 64'h0, 0);
    rsp_lat = 1;
    step(1, 0, 0, 64'h0, 64'h0, 1); expect_out("rst_r", 1, 64'h0, 0, 64'h0, 0);
    step(1, 0, 0, 64'h0, 64'h0, 1); expect_out("rst_w", 0, 64'h0, 0, 64'h0, 0);
    step(1, 0, 0, 64'h0, 64'h0, 1); expect_out("rst_h", 0, 64'h0, 1, 64'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
